reg_file: RTL and testbench

REG_FILE -- requirements
Module: reg_file

---
 rtl/reg_file.sv | 90 +++++++++
 tb/tb_reg_file.sv | 178 +++++++++++++++++
 2 files changed

// File: rtl/reg_file.sv
// reg_file: 2**ADDR_W x DATA_W register file, two combinational read ports, one write port.
// Self-clears via a post-reset sweep. Define REGFILE_BYPASS_EN for write-to-read forwarding.
module reg_file #(
   parameter int DATA_W = 32,
   parameter int ADDR_W = 5
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [ADDR_W-1:0] R_Addr_A,
   input  logic [ADDR_W-1:0] R_Addr_B,
   input  logic [ADDR_W-1:0] W_Addr,
   input  logic [DATA_W-1:0] W_Data,
   input  logic              Write_Reg,
   input  logic [1:0]        LED_SW,
   output logic [DATA_W-1:0] R_Data_A,
   output logic [DATA_W-1:0] R_Data_B,
   output logic              Busy,
   output logic [7:0]        LED
);

   typedef enum logic {IDLE, CLEAR} state_t;

   state_t            state;
   logic [ADDR_W-1:0] ptr;
   logic [DATA_W-1:0] regs [2**ADDR_W];
   logic              wr_en;

   assign Busy  = (state == CLEAR);
   assign wr_en = Write_Reg && (state == IDLE) && (W_Addr != '0) && !rst;

   // Reset only restarts the sweep; the sweep itself is what zeroes the array.
   always_ff @(posedge clk) begin
      if (rst) begin
         state <= CLEAR;
         ptr   <= '0;
      end else if (state == CLEAR) begin
         ptr <= ptr + ADDR_W'(1);
         if (ptr == '1) begin
            state <= IDLE;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         if (state == CLEAR) begin
            regs[ptr] <= '0;
         end else if (wr_en) begin
            regs[W_Addr] <= W_Data;
         end
      end
   end

   // Zero rules are applied last so they win over forwarding.
   always_comb begin
      R_Data_A = regs[R_Addr_A];
`ifdef REGFILE_BYPASS_EN
      if (wr_en && (R_Addr_A == W_Addr)) begin
         R_Data_A = W_Data;
      end
`endif
      if (rst || Busy || (R_Addr_A == '0)) begin
         R_Data_A = '0;
      end
   end

   always_comb begin
      R_Data_B = regs[R_Addr_B];
`ifdef REGFILE_BYPASS_EN
      if (wr_en && (R_Addr_B == W_Addr)) begin
         R_Data_B = W_Data;
      end
`endif
      if (rst || Busy || (R_Addr_B == '0)) begin
         R_Data_B = '0;
      end
   end

   always_comb begin
      LED = R_Data_A[7:0];
      case (LED_SW)
         2'b00: LED = R_Data_A[7:0];
         2'b01: LED = R_Data_A[15:8];
         2'b10: LED = R_Data_A[23:16];
         2'b11: LED = R_Data_A[31:24];
         default: LED = R_Data_A[7:0];
      endcase
   end

endmodule

// File: tb/tb_reg_file.sv
// tb_reg_file: directed and random stimulus for reg_file, checked against an array-based model.
// Honours REGFILE_BYPASS_EN the same way the design does.
module tb_reg_file;

   localparam int DATA_W = 32;
   localparam int ADDR_W = 5;
   localparam int NREG   = 32;

   logic              clk = 1'b0;
   logic              rst;
   logic [ADDR_W-1:0] r_addr_a, r_addr_b, w_addr;
   logic [DATA_W-1:0] w_data;
   logic              write_reg;
   logic [1:0]        led_sw;
   logic [DATA_W-1:0] r_data_a, r_data_b;
   logic              busy;
   logic [7:0]        led;

   int          n_vectors     = 0;
   int          n_miscompares = 0;
   bit          checks_on     = 1'b0;
   logic [31:0] mdl_mem [NREG];
   int          busy_left     = 0;

   reg_file #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) dut (
      .clk(clk), .rst(rst),
      .R_Addr_A(r_addr_a), .R_Addr_B(r_addr_b),
      .W_Addr(w_addr), .W_Data(w_data), .Write_Reg(write_reg),
      .LED_SW(led_sw),
      .R_Data_A(r_data_a), .R_Data_B(r_data_b),
      .Busy(busy), .LED(led)
   );

   always #5 clk = ~clk;

   task automatic applyStimulus(input logic r, input logic we, input logic [4:0] wa,
                                input logic [31:0] wd, input logic [4:0] ra,
                                input logic [4:0] rb, input logic [1:0] sw);
      rst       = r;
      write_reg = we;
      w_addr    = wa;
      w_data    = wd;
      r_addr_a  = ra;
      r_addr_b  = rb;
      led_sw    = sw;
   endtask

   // What a read of addr should return given current inputs and model contents.
   function automatic logic [31:0] exp_read(input logic [4:0] addr);
      if (rst || busy_left > 0 || addr == 5'd0) return 32'd0;
`ifdef REGFILE_BYPASS_EN
      if (write_reg && w_addr != 5'd0 && w_addr == addr) return w_data;
`endif
      return mdl_mem[addr];
   endfunction

   task automatic compare(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vectors++;
      assert (got === exp) else begin
         n_miscompares++;
         $error("[TB] FAIL %s: observed %h expected %h", tag, got, exp);
      end
   endtask

   task automatic checkOutput(input string tag);
      logic [31:0] ea, eb;
      int          sh;
      ea = exp_read(r_addr_a);
      eb = exp_read(r_addr_b);
      sh = 8 * int'(led_sw);
      compare({tag, "/busy"}, {31'd0, busy}, (busy_left > 0) ? 32'd1 : 32'd0);
      compare({tag, "/A"}, r_data_a, ea);
      compare({tag, "/B"}, r_data_b, eb);
      compare({tag, "/LED"}, {24'd0, led}, (ea >> sh) & 32'hFF);
   endtask

   // Advance one clock and apply the behavioural rules to the model.
   task automatic clockEdge();
      @(posedge clk);
      if (rst) begin
         busy_left = 32;
      end else if (busy_left > 0) begin
         busy_left--;
         if (busy_left == 0) begin
            for (int i = 0; i < NREG; i++) mdl_mem[i] = 32'd0;
         end
      end else if (write_reg && w_addr != 5'd0) begin
         mdl_mem[w_addr] = w_data;
      end
      #1;
   endtask

   task automatic step(input string tag, input logic r, input logic we, input logic [4:0] wa,
                       input logic [31:0] wd, input logic [4:0] ra, input logic [4:0] rb,
                       input logic [1:0] sw);
      applyStimulus(r, we, wa, wd, ra, rb, sw);
      #1;
      if (checks_on) checkOutput(tag);
      clockEdge();
   endtask

   function automatic logic [4:0] rnd_addr();
      return 5'($urandom_range(0, 31));
   endfunction

   initial begin
      int busy_seen;
      for (int i = 0; i < NREG; i++) mdl_mem[i] = 'x;

      // Power-up reset: the first edge establishes state, then rst is held one more cycle.
      step("rst0", 1'b1, 1'b0, 5'd0, 32'd0, 5'd1, 5'd2, 2'b00);
      checks_on = 1'b1;
      step("rst_hold", 1'b1, 1'b1, 5'd4, 32'hCAFEF00D, 5'd4, 5'd5, 2'b01);

      // Sweep, with a write attempt to r3 at sweep cycle 5.
      for (int c = 0; c < 32; c++) begin
         if (c == 5)
            step("sweep_wr", 1'b0, 1'b1, 5'd3, 32'hDEADBEEF, 5'd3, 5'd3, 2'b11);
         else
            step("sweep", 1'b0, 1'b0, 5'd0, $urandom, rnd_addr(), rnd_addr(), 2'($urandom));
      end

      for (int i = 0; i < 16; i++)
         step("clear_read", 1'b0, 1'b0, 5'd0, 32'd0, 5'(2*i), 5'(2*i+1), 2'(i));

      step("wr6", 1'b0, 1'b1, 5'd6, 32'h12345678, 5'd1, 5'd2, 2'b00);
      step("wr7", 1'b0, 1'b1, 5'd7, 32'h33332222, 5'd1, 5'd2, 2'b00);
      applyStimulus(1'b0, 1'b0, 5'd0, 32'd0, 5'd6, 5'd7, 2'b11);
      #1;
      checkOutput("rd67");
      compare("rd6_const", r_data_a, 32'h12345678);
      compare("rd7_const", r_data_b, 32'h33332222);
      compare("led_top_byte", {24'd0, led}, 32'h12);
      clockEdge();

      step("wr_r0", 1'b0, 1'b1, 5'd0, 32'hFFFFFFFF, 5'd0, 5'd0, 2'b00);
      step("rd_r0", 1'b0, 1'b0, 5'd0, 32'd0, 5'd0, 5'd0, 2'b10);
      step("rd_r3", 1'b0, 1'b0, 5'd0, 32'd0, 5'd3, 5'd3, 2'b01);

      step("r9_prior", 1'b0, 1'b1, 5'd9, 32'h11112222, 5'd6, 5'd7, 2'b00);
      step("r9_same_cycle", 1'b0, 1'b1, 5'd9, 32'h9ABCDEF0, 5'd9, 5'd9, 2'b00);
      step("r9_after", 1'b0, 1'b0, 5'd0, 32'd0, 5'd9, 5'd9, 2'b10);

      // Random traffic, including the occasional reset and shared read addresses.
      for (int n = 0; n < 300; n++) begin
         logic [4:0] ra, wa;
         ra = rnd_addr();
         wa = ($urandom_range(0, 3) == 0) ? ra : rnd_addr();
         step("rand", ($urandom_range(0, 99) == 0), 1'($urandom), wa, $urandom, ra,
              ($urandom_range(0, 3) == 0) ? ra : rnd_addr(), 2'($urandom));
      end

      // Mid-sweep reset: restart at sweep cycle 20 and count the full busy window again.
      for (int c = 0; c < 40 && busy_left > 0; c++)
         step("drain", 1'b0, 1'b0, 5'd0, 32'd0, rnd_addr(), rnd_addr(), 2'b00);
      step("wr_pre", 1'b0, 1'b1, 5'd12, 32'hA5A5A5A5, 5'd12, 5'd12, 2'b00);
      step("rst_a", 1'b1, 1'b0, 5'd0, 32'd0, 5'd12, 5'd0, 2'b00);
      for (int c = 0; c < 20; c++)
         step("sweep_a", 1'b0, 1'b1, rnd_addr(), $urandom, rnd_addr(), rnd_addr(), 2'b00);
      step("rst_b", 1'b1, 1'b0, 5'd0, 32'd0, 5'd12, 5'd12, 2'b00);
      busy_seen = 0;
      for (int c = 0; c < 40; c++) begin
         applyStimulus(1'b0, 1'b0, 5'd0, 32'd0, rnd_addr(), rnd_addr(), 2'b00);
         #1;
         checkOutput("sweep_b");
         if (busy === 1'b1) busy_seen++;
         clockEdge();
      end
      compare("busy_cycles_after_midreset", 32'(busy_seen), 32'd32);

      for (int i = 0; i < 16; i++)
         step("final_read", 1'b0, 1'b0, 5'd0, 32'd0, 5'(2*i), 5'(31-2*i), 2'(i));

      $display("== %0d vectors applied, %0d miscompares ==", n_vectors, n_miscompares);
      $finish;
   end

endmodule
